// File: rtl/morse_pkg.sv
// Shared constants and state encoding for the Morse receive path.
package morse_pkg;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  // Duration thresholds in Morse units
  localparam int unsigned DASH_MIN   = 2;
  localparam int unsigned LETTER_GAP = 2;
  localparam int unsigned WORD_GAP   = 5;
  localparam int unsigned SAT_UNITS  = 8;

  localparam int unsigned LEN_W  = 3;
  localparam int unsigned SYM_W  = 5;
  localparam int unsigned CHAR_W = 8;

  localparam logic [CHAR_W-1:0] SPACE   = 8'h20;
  localparam logic [CHAR_W-1:0] UNKNOWN = 8'h3F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MARK    = 2'd1,
    GAP_SYM = 2'd2,
    GAP_CHR = 2'd3
  } state_t;

endpackage

// File: rtl/morse_lut.sv
// Symbol pattern to ASCII table; first symbol in bit 0, dash = 1.
module morse_lut
  import morse_pkg::*;
(
  input  logic [LEN_W-1:0]  len,
  input  logic [SYM_W-1:0]  bits,
  output logic [CHAR_W-1:0] ascii,
  output logic              hit
);

  always_comb begin
    ascii = UNKNOWN;
    hit   = 1'b1;
    case ({len, bits})
      8'b010_00010: ascii = 8'h41; // A .-
      8'b100_00001: ascii = 8'h42; // B -...
      8'b100_00101: ascii = 8'h43; // C -.-.
      8'b011_00001: ascii = 8'h44; // D -..
      8'b001_00000: ascii = 8'h45; // E .
      8'b100_00100: ascii = 8'h46; // F ..-.
      8'b011_00011: ascii = 8'h47; // G --.
      8'b100_00000: ascii = 8'h48; // H ....
      8'b010_00000: ascii = 8'h49; // I ..
      8'b100_01110: ascii = 8'h4A; // J .---
      8'b011_00101: ascii = 8'h4B; // K -.-
      8'b100_00010: ascii = 8'h4C; // L .-..
      8'b010_00011: ascii = 8'h4D; // M --
      8'b010_00001: ascii = 8'h4E; // N -.
      8'b011_00111: ascii = 8'h4F; // O ---
      8'b100_00110: ascii = 8'h50; // P .--.
      8'b100_01011: ascii = 8'h51; // Q --.-
      8'b011_00010: ascii = 8'h52; // R .-.
      8'b011_00000: ascii = 8'h53; // S ...
      8'b001_00001: ascii = 8'h54; // T -
      8'b011_00100: ascii = 8'h55; // U ..-
      8'b100_01000: ascii = 8'h56; // V ...-
      8'b011_00110: ascii = 8'h57; // W .--
      8'b100_01001: ascii = 8'h58; // X -..-
      8'b100_01101: ascii = 8'h59; // Y -.--
      8'b100_00011: ascii = 8'h5A; // Z --..
      8'b101_11111: ascii = 8'h30; // 0
      8'b101_11110: ascii = 8'h31; // 1
      8'b101_11100: ascii = 8'h32; // 2
      8'b101_11000: ascii = 8'h33; // 3
      8'b101_10000: ascii = 8'h34; // 4
      8'b101_00000: ascii = 8'h35; // 5
      8'b101_00001: ascii = 8'h36; // 6
      8'b101_00011: ascii = 8'h37; // 7
      8'b101_00111: ascii = 8'h38; // 8
      8'b101_01111: ascii = 8'h39; // 9
      default:      hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: synchronise and debounce the key, time marks/spaces,
// and emit one ASCII character (or a word space) per decoded letter.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 12500000,
  parameter int unsigned DEBOUNCE       = 500000,
  parameter int unsigned MAX_SYM        = 5
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iKEY,
  output logic [CHAR_W-1:0] oCHAR,
  output logic              oVALID,
  output logic              oERR,
  output logic              oKEY
);

  localparam int unsigned SAT  = SAT_UNITS * TICKS_PER_UNIT;
  localparam int unsigned CNT_W = $clog2(SAT + 1);
  localparam int unsigned DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [CNT_W-1:0] DUR_SAT   = CNT_W'(SAT);
  localparam logic [CNT_W-1:0] DASH_TH   = CNT_W'(DASH_MIN * TICKS_PER_UNIT);
  localparam logic [CNT_W-1:0] LETTER_TH = CNT_W'(LETTER_GAP * TICKS_PER_UNIT);
  localparam logic [CNT_W-1:0] WORD_TH   = CNT_W'(WORD_GAP * TICKS_PER_UNIT);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [LEN_W-1:0] FULL      = LEN_W'(MAX_SYM);

  logic              key_s1, key_s2, key_prev;
  logic [DB_W-1:0]   db_cnt;
  logic [CNT_W-1:0]  dur;
  state_t            state;
  logic [MAX_SYM-1:0] sym_bits;
  logic [LEN_W-1:0]  sym_cnt;
  logic              ovf, space_pending;
  logic [CHAR_W-1:0] lut_ascii;
  logic              lut_hit;
  logic              rise_c, fall_c;

  assign rise_c = oKEY & ~key_prev;
  assign fall_c = ~oKEY & key_prev;

  morse_lut u_lut (
    .len   (sym_cnt),
    .bits  (SYM_W'(sym_bits)),
    .ascii (lut_ascii),
    .hit   (lut_hit)
  );

  // Synchroniser, debounce and duration counter (restarts one cycle after each accepted edge)
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      key_s1   <= 1'b0;
      key_s2   <= 1'b0;
      oKEY     <= 1'b0;
      key_prev <= 1'b0;
      db_cnt   <= '0;
      dur      <= '0;
    end else begin
      key_s1   <= iKEY;
      key_s2   <= key_s1;
      key_prev <= oKEY;
      if (key_s2 == oKEY) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        oKEY   <= key_s2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      if (oKEY != key_prev) begin
        dur <= CNT_W'(1);
      end else if (dur != DUR_SAT) begin
        dur <= dur + CNT_W'(1);
      end
    end
  end

  // Symbol collection and character/space emission
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state         <= IDLE;
      sym_bits      <= '0;
      sym_cnt       <= '0;
      ovf           <= 1'b0;
      space_pending <= 1'b0;
      oCHAR         <= '0;
      oVALID        <= 1'b0;
      oERR          <= 1'b0;
    end else begin
      oVALID <= 1'b0;
      oERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_c) state <= MARK;
        end
        MARK: begin
          if (fall_c) begin
            if (sym_cnt == FULL) begin
              ovf <= 1'b1;
            end else begin
              sym_bits[sym_cnt] <= (dur >= DASH_TH) ? DASH : DOT;
              sym_cnt           <= sym_cnt + LEN_W'(1);
            end
            state <= GAP_SYM;
          end
        end
        GAP_SYM: begin
          if (rise_c) begin
            state <= MARK;
          end else if (dur == LETTER_TH) begin
            oVALID        <= 1'b1;
            oCHAR         <= (ovf || !lut_hit) ? UNKNOWN : lut_ascii;
            oERR          <= ovf || !lut_hit;
            sym_bits      <= '0;
            sym_cnt       <= '0;
            ovf           <= 1'b0;
            space_pending <= 1'b1;
            state         <= GAP_CHR;
          end
        end
        GAP_CHR: begin
          if (rise_c) begin
            state <= MARK;
          end else if (dur == WORD_TH) begin
            if (space_pending) begin
              oVALID <= 1'b1;
              oCHAR  <= SPACE;
            end
            space_pending <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
